// File: rtl/label_ram_if.sv
// Bundle of request and response signals for the multi-port label store.
// The master (label producer/consumer) drives strobes, addresses and data;
// the slave (label_ram_mp) returns status and registered read results.
interface label_ram_if #(
    parameter int S = 10,
    parameter int K = 128,
    parameter int P = 2
);
    logic                  clr;
    logic [P-1:0]          wr_en;
    logic [P-1:0][S-1:0]   wr_addr;
    logic [P-1:0][K-1:0]   wr_data;
    logic [P-1:0]          rd_en;
    logic [P-1:0][S-1:0]   rd_addr;
    logic                  init_done;
    logic [P-1:0]          busy;
    logic [P-1:0]          rd_valid;
    logic [P-1:0]          rd_hit;
    logic [P-1:0][K-1:0]   rd_data;
    logic [S:0]            valid_count;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  init_done, busy, rd_valid, rd_hit, rd_data, valid_count
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output init_done, busy, rd_valid, rd_hit, rd_data, valid_count
    );
endinterface

// File: rtl/label_ram_mp.sv
// Multi-port wire-label memory with per-entry valid flags, same-cycle
// write-to-read forwarding, lowest-port-wins write arbitration and a
// zeroing sweep after reset or clear.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SWEEP | each port zeroes one entry per cycle; all accesses ignored
// ST_IDLE  | normal writes/reads; port busy only when it is writing
module label_ram_mp #(
    parameter int S = 10,
    parameter int K = 128,
    parameter int P = 2
) (
    input  logic      clk,
    input  logic      rst,
    label_ram_if.slave bus
);
    localparam int DEPTH = 1 << S;
    localparam int NIDX  = DEPTH / P;
    localparam int IW    = (NIDX > 1) ? $clog2(NIDX) : 1;

    typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [K-1:0]         mem [DEPTH];
    logic [DEPTH-1:0]     flags;
    logic [S:0]           count;
    logic [P-1:0]         rd_valid_q;
    logic [P-1:0]         rd_hit_q;
    logic [P-1:0][K-1:0]  rd_data_q;

    logic [P-1:0]         win;
    logic [P-1:0]         acc;
    logic [P-1:0][K-1:0]  rd_word;
    logic [P-1:0]         rd_flag;
    logic [S:0]           inc;

    // Write arbitration, new-entry count, read acceptance and forwarding.
    always_comb begin
        win     = '0;
        acc     = '0;
        rd_word = '0;
        rd_flag = '0;
        inc     = '0;
        for (int p = 0; p < P; p++) begin
            win[p] = bus.wr_en[p];
            for (int q = 0; q < p; q++) begin
                if (bus.wr_en[q] && (bus.wr_addr[q] == bus.wr_addr[p]))
                    win[p] = 1'b0;
            end
        end
        for (int p = 0; p < P; p++) begin
            // Winners hit distinct addresses, so each one can add at most one.
            if (win[p] && !flags[bus.wr_addr[p]])
                inc = inc + (S+1)'(1);
            acc[p]     = (state == ST_IDLE) && !bus.clr && bus.rd_en[p] && !bus.wr_en[p];
            rd_word[p] = mem[bus.rd_addr[p]];
            rd_flag[p] = flags[bus.rd_addr[p]];
            for (int q = 0; q < P; q++) begin
                if (win[q] && (bus.wr_addr[q] == bus.rd_addr[p])) begin
                    rd_word[p] = bus.wr_data[q];
                    rd_flag[p] = 1'b1;
                end
            end
        end
    end

    // Control FSM with flags, occupancy count and registered read results.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state      <= ST_SWEEP;
            idx        <= '0;
            flags      <= '0;
            count      <= '0;
            rd_valid_q <= '0;
            rd_hit_q   <= '0;
            if (rst)
                rd_data_q <= '0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    rd_valid_q <= '0;
                    rd_hit_q   <= '0;
                    if (idx == IW'(NIDX - 1)) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_IDLE: begin
                    for (int p = 0; p < P; p++) begin
                        if (win[p])
                            flags[bus.wr_addr[p]] <= 1'b1;
                        if (acc[p])
                            rd_data_q[p] <= rd_word[p];
                    end
                    count      <= count + inc;
                    rd_valid_q <= acc;
                    rd_hit_q   <= acc & rd_flag;
                end
                default: state <= ST_SWEEP;
            endcase
        end
    end

    // Storage: zeroing sweep stripes across ports, otherwise winning writes.
    always_ff @(posedge clk) begin
        if (!rst && !bus.clr) begin
            if (state == ST_SWEEP) begin
                for (int p = 0; p < P; p++)
                    mem[S'(int'(idx) * P + p)] <= '0;
            end else begin
                for (int p = 0; p < P; p++) begin
                    if (win[p])
                        mem[bus.wr_addr[p]] <= bus.wr_data[p];
                end
            end
        end
    end

    assign bus.busy        = (rst || state != ST_IDLE) ? '1 : bus.wr_en;
    assign bus.init_done   = (state == ST_IDLE);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_hit      = rd_hit_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.valid_count = count;
endmodule

// File: tb/tb_label_ram_mp.sv
// Randomised and directed bench for label_ram_mp against a behavioural
// model: an array of labels, an array of flags and a sweep-cycles-left count.
module tb_label_ram_mp;
    localparam int S = 4;
    localparam int K = 8;
    localparam int P = 2;
    localparam int N = 1 << S;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    label_ram_if #(.S(S), .K(K), .P(P)) bus ();

    label_ram_mp #(.S(S), .K(K), .P(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [K-1:0] m_mem  [N];
    logic         m_flag [N];
    int           sweep_left;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int flag_total();
        int n = 0;
        for (int i = 0; i < N; i++)
            if (m_flag[i]) n++;
        return n;
    endfunction

    task automatic idle_inputs();
        bus.clr     = 1'b0;
        bus.wr_en   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = '0;
        bus.rd_addr = '0;
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic cyc();
        logic [P-1:0]        ev;
        logic [P-1:0]        eh;
        logic [P-1:0][K-1:0] ed;
        logic [N-1:0]        wrote;
        ev = '0; eh = '0; ed = '0; wrote = '0;
        #1;
        chk("busy", 32'(bus.busy),
            (rst || sweep_left > 0) ? 32'(2'b11) : 32'(bus.wr_en));
        if (rst || bus.clr) begin
            sweep_left = N / P;
            for (int i = 0; i < N; i++) begin
                m_mem[i]  = '0;
                m_flag[i] = 1'b0;
            end
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            for (int p = 0; p < P; p++) begin
                if (bus.wr_en[p] && !wrote[bus.wr_addr[p]]) begin
                    wrote[bus.wr_addr[p]] = 1'b1;
                    m_mem[bus.wr_addr[p]]  = bus.wr_data[p];
                    m_flag[bus.wr_addr[p]] = 1'b1;
                end
            end
            for (int p = 0; p < P; p++) begin
                if (bus.rd_en[p] && !bus.wr_en[p]) begin
                    ev[p] = 1'b1;
                    eh[p] = m_flag[bus.rd_addr[p]];
                    ed[p] = m_mem[bus.rd_addr[p]];
                end
            end
        end
        @(posedge clk);
        #1;
        chk("init_done", 32'(bus.init_done), 32'(sweep_left == 0));
        chk("valid_count", 32'(bus.valid_count), 32'(flag_total()));
        for (int p = 0; p < P; p++) begin
            chk($sformatf("rd_valid%0d", p), 32'(bus.rd_valid[p]), 32'(ev[p]));
            if (ev[p]) begin
                chk($sformatf("rd_hit%0d", p), 32'(bus.rd_hit[p]), 32'(eh[p]));
                chk($sformatf("rd_data%0d", p), 32'(bus.rd_data[p]), 32'(ed[p]));
            end
        end
        if (rst) begin
            chk("rst_rd_hit", 32'(bus.rd_hit), 32'(0));
            chk("rst_rd_data", 32'(bus.rd_data), 32'(0));
        end
    endtask

    task automatic do_write(input int p, input int a, input logic [K-1:0] d);
        bus.wr_en[p]   = 1'b1;
        bus.wr_addr[p] = S'(a);
        bus.wr_data[p] = d;
    endtask

    task automatic do_read(input int p, input int a);
        bus.rd_en[p]   = 1'b1;
        bus.rd_addr[p] = S'(a);
    endtask

    initial begin
        sweep_left = N / P;
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_flag[i] = 1'b0;
        end
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        // Sweep: model expects init_done low for exactly N/P cycles.
        for (int i = 0; i < N / P; i++) cyc();
        chk("init_after_rst", 32'(bus.init_done), 32'(1));

        // Every address reads as unwritten zero.
        for (int i = 0; i < N / P; i++) begin
            idle_inputs();
            do_read(0, 2 * i);
            do_read(1, 2 * i + 1);
            cyc();
        end

        // Write then read from storage.
        idle_inputs(); do_write(0, 3, 8'hA5); cyc();
        idle_inputs(); do_read(1, 3); cyc();
        chk("wr_rd_data", 32'(bus.rd_data[1]), 32'h0A5);
        chk("wr_rd_count", 32'(bus.valid_count), 32'(1));

        // Forwarding.
        idle_inputs(); do_write(0, 7, 8'h3C); do_read(1, 7); cyc();
        chk("fwd_data", 32'(bus.rd_data[1]), 32'h03C);

        // Collision: port 0 wins, count moves by one; rewrite leaves count.
        idle_inputs(); do_write(0, 9, 8'h11); do_write(1, 9, 8'h22); cyc();
        chk("coll_count", 32'(bus.valid_count), 32'(3));
        idle_inputs(); do_read(0, 9); cyc();
        chk("coll_data", 32'(bus.rd_data[0]), 32'h011);
        idle_inputs(); do_write(1, 9, 8'h33); cyc();
        chk("rewrite_count", 32'(bus.valid_count), 32'(3));

        // Clear during an accepted read.
        idle_inputs(); do_write(0, 10, 8'h44); do_write(1, 11, 8'h55); cyc();
        chk("fill_count", 32'(bus.valid_count), 32'(5));
        idle_inputs(); do_read(1, 3); bus.clr = 1'b1; cyc();
        chk("clr_no_valid", 32'(bus.rd_valid), 32'(0));
        chk("clr_count", 32'(bus.valid_count), 32'(0));
        idle_inputs();
        for (int i = 0; i < N / P; i++) cyc();
        idle_inputs(); do_read(0, 3); do_read(1, 7); cyc();
        idle_inputs(); do_read(0, 9); do_read(1, 10); cyc();

        // Busy: write wins over a same-port read.
        idle_inputs(); do_write(0, 4, 8'h66); do_read(0, 4); cyc();
        idle_inputs(); do_read(1, 4); cyc();

        // Sweep restart by clr at sweep cycle 4.
        idle_inputs(); bus.clr = 1'b1; cyc();
        idle_inputs();
        for (int i = 0; i < 4; i++) cyc();
        bus.clr = 1'b1; cyc();
        idle_inputs();
        for (int i = 0; i < N / P; i++) cyc();
        chk("restart_done", 32'(bus.init_done), 32'(1));

        // Randomised traffic with occasional clr and rst.
        for (int n = 0; n < 800; n++) begin
            idle_inputs();
            rst     = ($urandom_range(0, 299) == 0);
            bus.clr = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < P; p++) begin
                bit narrow;
                narrow = ($urandom_range(0, 1) == 1);
                bus.wr_en[p]   = ($urandom_range(0, 2) == 0);
                bus.wr_addr[p] = S'(narrow ? $urandom_range(0, 3) : $urandom_range(0, N - 1));
                bus.wr_data[p] = K'($urandom);
                bus.rd_en[p]   = ($urandom_range(0, 1) == 1);
                bus.rd_addr[p] = S'(narrow ? $urandom_range(0, 3) : $urandom_range(0, N - 1));
            end
            cyc();
        end
        rst = 1'b0;
        idle_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
